mult_table_stream: RTL

- Parametrised successor to the fixed three-times table generator.
- On a start pulse, latches a run-time multiplicand and table length, then streams (index, multiplicand*index) entries for index = 0..last_index over a valid/ready interface.
- Uses a repeated-add accumulator, so there is no multiplier in the datapath.
- Sits between the control/stimulus logic and any downstream consumer (display, checker, FIFO) that may apply backpressure.

---
 rtl/mult_table_pkg.sv | 19 +
 rtl/mult_table_stream.sv | 118 +++++++++++
 2 files changed

// File: rtl/mult_table_pkg.sv
// mult_table_pkg
//   Shared definitions for the multiplication-table streamer: FSM state
//   encoding, default widths and the result-width derivation.
package mult_table_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IDX_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A table entry is at most (2^d-1)*(2^i-1), which always fits in d+i bits.
  function automatic int res_w(input int data_w, input int idx_w);
    return data_w + idx_w;
  endfunction

endpackage

// File: rtl/mult_table_stream.sv
// mult_table_stream
//   On an accepted start, latches a multiplicand and a last index. It then
//   streams (index, multiplicand*index) for index = 0..last_index. The product
//   comes from a repeated-add accumulator, so the datapath has no multiplier.
//
// Ports
//   clk          : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   start        : begin a table (sampled only in IDLE)
//   multiplicand : table multiplier, latched on accepted start
//   last_index   : final index (inclusive), latched on accepted start
//   out_ready    : consumer accepts the current entry
//   out_valid    : current entry valid
//   out_index    : index of current entry
//   out_result   : multiplicand * out_index
//   out_last     : current entry is the final one
//   busy         : high while streaming (RUN)
//   done         : one-cycle pulse after the final entry is consumed
//   dbg_state    : current FSM state
//
// Handshake: an entry transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, every out_* signal holds
// stable. out_ready has no effect while out_valid is low.
module mult_table_stream
  import mult_table_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  // Derived; overriding it smaller would truncate the largest products.
  parameter int RES_W  = res_w(DATA_W, IDX_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [IDX_W-1:0]  last_index,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_index,
  output logic [RES_W-1:0]  out_result,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_mcand;
  logic [IDX_W-1:0]    r_last;
  logic                r_valid;
  logic [IDX_W-1:0]    r_index;
  logic [RES_W-1:0]    r_result;
  logic                r_last_flag;
  logic                r_done;

  logic                w_hs;
  logic [IDX_W-1:0]    w_next_index;
  logic [RES_W-1:0]    w_mcand_ext;

  assign w_hs         = r_valid && out_ready;
  assign w_next_index = r_index + IDX_W'(1);
  // Zero-extend the latched multiplicand to the accumulator width.
  assign w_mcand_ext  = RES_W'(r_mcand);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_last      <= '0;
      r_valid     <= 1'b0;
      r_index     <= '0;
      r_result    <= '0;
      r_last_flag <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand     <= multiplicand;
            r_last      <= last_index;
            r_index     <= '0;
            r_result    <= '0;
            r_last_flag <= (last_index == '0);
            r_valid     <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          // start is deliberately ignored here: there is no queuing and no restart.
          if (w_hs) begin
            if (r_last_flag) begin
              // Index and result keep their final values after the run ends.
              r_state     <= IDLE;
              r_valid     <= 1'b0;
              r_last_flag <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_index     <= w_next_index;
              r_result    <= r_result + w_mcand_ext;
              r_last_flag <= (w_next_index == r_last);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_index  = r_index;
  assign out_result = r_result;
  assign out_last   = r_last_flag;
  assign busy       = (r_state == RUN);
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule
